// File: rtl/ace_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states and op codes.
package ace_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between decode-stall logic (master) and the sequencer (slave).
interface muldiv_seq_if #(parameter int N = 32);
    logic         start;
    logic         op;
    logic         sgn;
    logic [N-1:0] s;
    logic [N-1:0] t;
    logic         busy;
    logic         done;
    logic [N-1:0] result_lo;
    logic [N-1:0] result_hi;
    logic         overflow;

    modport master (
        output start, op, sgn, s, t,
        input  busy, done, result_lo, result_hi, overflow
    );

    modport slave (
        input  start, op, sgn, s, t,
        output busy, done, result_lo, result_hi, overflow
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply (LSB first) or restoring divide (MSB first).
module muldiv_step
    import ace_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         i_op,
    input  logic [N-1:0] i_acc,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_opnd,
    output logic [N-1:0] o_acc,
    output logic [N-1:0] o_q
);
    logic [N:0] w_sum;
    logic [N:0] w_shift;
    logic [N:0] w_sub;
    logic       w_ge;
    logic       w_unused_sub_top;

    // Remainder is always below the divisor, so the top bit of the difference is never kept.
    assign w_sum            = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opnd} : '0);
    assign w_shift          = {i_acc, i_q[N-1]};
    assign w_ge             = (w_shift >= {1'b0, i_opnd});
    assign w_sub            = w_shift - {1'b0, i_opnd};
    assign w_unused_sub_top = w_sub[N];

    always_comb begin
        o_acc = i_acc;
        o_q   = i_q;
        if (i_op == MD_OP_MUL) begin
            o_acc = w_sum[N:1];
            o_q   = {w_sum[0], i_q[N-1:1]};
        end else begin
            o_acc = w_ge ? w_sub[N-1:0] : w_shift[N-1:0];
            o_q   = {i_q[N-2:0], w_ge};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer, one bit per cycle. Signed support under `MULDIV_SIGNED_EN.
// state   | meaning
// MD_IDLE | waiting for start
// MD_CALC | iterating (or flagging divide-by-zero)
// MD_DONE | one-cycle done pulse, results valid
module muldiv_seq
    import ace_pkg::*;
#(
    parameter int N    = 32,
    parameter int CNTW = 6
) (
    input  logic           i_clk,
    input  logic           i_reset,
    muldiv_seq_if.slave    bus
);
    md_state_t      r_state, w_next_state;
    logic [CNTW-1:0] r_cnt;
    logic           r_op;
    logic [N-1:0]   r_acc;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_opnd;
    logic           r_div0;
    logic [N-1:0]   r_lo;
    logic [N-1:0]   r_hi;
    logic           r_ovf;
    logic [N-1:0]   w_acc_nxt, w_q_nxt;
    logic [N-1:0]   w_mag_s, w_mag_t;
    logic [N-1:0]   w_lo_u, w_hi_u, w_fin_lo, w_fin_hi;
    logic           w_fin_ovf;
    logic           w_accept, w_finish;
`ifdef MULDIV_SIGNED_EN
    logic           r_sgn, r_neg_a, r_neg_r, r_ovf_min;
    logic           w_neg_s, w_neg_t;
    logic [2*N-1:0] w_prod_neg;

    assign w_neg_s = bus.sgn & bus.s[N-1];
    assign w_neg_t = bus.sgn & bus.t[N-1];
    assign w_mag_s = w_neg_s ? -bus.s : bus.s;
    assign w_mag_t = w_neg_t ? -bus.t : bus.t;
`else
    logic           w_unused_sgn;

    assign w_unused_sgn = bus.sgn;
    assign w_mag_s      = bus.s;
    assign w_mag_t      = bus.t;
`endif

    muldiv_step #(.N(N)) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt),
        .o_q    (w_q_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= MD_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MD_IDLE: if (bus.start) w_next_state = MD_CALC;
            MD_CALC: if (r_div0 || (r_cnt == CNTW'(N-1))) w_next_state = MD_DONE;
            MD_DONE: w_next_state = MD_IDLE;
            default: w_next_state = MD_IDLE;
        endcase
    end

    assign w_accept = (r_state == MD_IDLE) && bus.start;
    assign w_finish = (r_state == MD_CALC) && (w_next_state == MD_DONE);

    // Divide-by-zero skips iteration: r_q still holds the dividend magnitude.
    always_comb begin
        w_lo_u   = r_div0 ? '0 : w_q_nxt;
        w_hi_u   = r_div0 ? r_q : w_acc_nxt;
        w_fin_lo = w_lo_u;
        w_fin_hi = w_hi_u;
`ifdef MULDIV_SIGNED_EN
        w_prod_neg = -{w_hi_u, w_lo_u};
        if (r_op == MD_OP_MUL) begin
            if (r_neg_a) {w_fin_hi, w_fin_lo} = w_prod_neg;
        end else begin
            if (r_neg_a) w_fin_lo = -w_lo_u;
            if (r_neg_r) w_fin_hi = -w_hi_u;
        end
        if (r_op == MD_OP_MUL)
            w_fin_ovf = r_sgn ? (w_fin_hi != {N{w_fin_lo[N-1]}}) : (w_fin_hi != '0);
        else
            w_fin_ovf = r_div0 | r_ovf_min;
`else
        if (r_op == MD_OP_MUL) w_fin_ovf = (w_fin_hi != '0);
        else                   w_fin_ovf = r_div0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_op   <= MD_OP_MUL;
            r_acc  <= '0;
            r_q    <= '0;
            r_opnd <= '0;
            r_div0 <= 1'b0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_ovf  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_sgn     <= 1'b0;
            r_neg_a   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_ovf_min <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_op   <= bus.op;
            r_acc  <= '0;
            r_q    <= (bus.op == MD_OP_MUL) ? w_mag_t : w_mag_s;
            r_opnd <= (bus.op == MD_OP_MUL) ? w_mag_s : w_mag_t;
            r_div0 <= (bus.op == MD_OP_DIV) && (bus.t == '0);
`ifdef MULDIV_SIGNED_EN
            r_sgn     <= bus.sgn;
            r_neg_a   <= w_neg_s ^ w_neg_t;
            r_neg_r   <= w_neg_s;
            r_ovf_min <= (bus.op == MD_OP_DIV) && bus.sgn &&
                         (bus.s == {1'b1, {(N-1){1'b0}}}) && (bus.t == '1);
`endif
        end else if (r_state == MD_CALC) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CNTW'(1);
            if (w_finish) begin
                r_lo  <= w_fin_lo;
                r_hi  <= w_fin_hi;
                r_ovf <= w_fin_ovf;
            end
        end
    end

    assign bus.busy      = (r_state == MD_CALC);
    assign bus.done      = (r_state == MD_DONE);
    assign bus.result_lo = r_lo;
    assign bus.result_hi = r_hi;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases plus randomized ops vs. arithmetic model.
module tb_muldiv_seq;
    import ace_pkg::*;

    localparam int N = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] lo;
        logic [N-1:0] hi;
        logic         ov;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_seq_if #(.N(N)) bus();

    muldiv_seq #(.N(N), .CNTW(6)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic op, input logic sgn,
                                   input logic [N-1:0] s, input logic [N-1:0] t);
        exp_t e;
        longint unsigned pu;
        longint ps;
        int si, ti;
        e.due = 0;
        si = s;
        ti = t;
        if (op == MD_OP_MUL) begin
            if (sgn && SIGNED_EN) begin
                ps   = longint'(si) * longint'(ti);
                e.lo = ps[31:0];
                e.hi = ps[63:32];
                e.ov = (ps < -64'sd2147483648) || (ps > 64'sd2147483647);
            end else begin
                pu   = longint'(s) * longint'(t);
                e.lo = pu[31:0];
                e.hi = pu[63:32];
                e.ov = (pu > 64'hFFFF_FFFF);
            end
        end else if (t == 0) begin
            e.lo = 0;
            e.hi = s;
            e.ov = 1'b1;
        end else if (sgn && SIGNED_EN) begin
            if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = 0;
                e.ov = 1'b1;
            end else begin
                e.lo = si / ti;
                e.hi = si % ti;
                e.ov = 1'b0;
            end
        end else begin
            e.lo = s / t;
            e.hi = s % t;
            e.ov = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("result_lo", 64'(bus.result_lo), 64'(e.lo));
                chk("result_hi", 64'(bus.result_hi), 64'(e.hi));
                chk("overflow",  64'(bus.overflow),  64'(e.ov));
                chk("latency",   64'(cyc),           64'(e.due));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((bus.busy || bus.done) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("idle_timeout", 64'(k), 64'(0));
    endtask

    task automatic drive(input logic op, input logic sgn, input logic [N-1:0] s, input logic [N-1:0] t);
        bus.op  = op;
        bus.sgn = sgn;
        bus.s   = s;
        bus.t   = t;
    endtask

    task automatic issue(input logic op, input logic sgn, input logic [N-1:0] s, input logic [N-1:0] t);
        exp_t e;
        wait_idle();
        drive(op, sgn, s, t);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        e = model(op, sgn, s, t);
        e.due = (op == MD_OP_DIV && t == 0) ? cyc + 1 : cyc + N;
        sb.push_back(e);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return 0;
            1:       return 1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 300));
            5:       return -32'($urandom_range(1, 300));
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int nb;
        reset     = 1'b1;
        bus.start = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_lo",   64'(bus.result_lo), 0);
        chk("rst_hi",   64'(bus.result_hi), 0);
        chk("rst_ovf",  64'(bus.overflow), 0);
        reset = 1'b0;
        @(negedge clk);

        // MUL 7x6 with busy-width check
        issue(MD_OP_MUL, 0, 7, 6);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) break;
            if (bus.busy) nb++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(nb), 64'(N));

        issue(MD_OP_MUL, 0, 32'hFFFF_FFFF, 2);
        issue(MD_OP_DIV, 0, 100, 7);
        issue(MD_OP_DIV, 0, 5, 0);

        // Start while busy is dropped; the following start is taken normally
        issue(MD_OP_DIV, 0, 1000, 3);
        repeat (9) @(negedge clk);
        drive(MD_OP_MUL, 0, 3, 3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        issue(MD_OP_MUL, 0, 3, 3);

        // Reset mid-DIV aborts with zeroed outputs and no done
        issue(MD_OP_DIV, 0, 12345, 67);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 0);
        chk("abort_done", 64'(bus.done), 0);
        chk("abort_lo",   64'(bus.result_lo), 0);
        chk("abort_hi",   64'(bus.result_hi), 0);
        chk("abort_ovf",  64'(bus.overflow), 0);
        reset = 1'b0;
        repeat (N + 5) @(negedge clk);

        issue(MD_OP_DIV, 1, -32'd7, 2);
        issue(MD_OP_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(MD_OP_MUL, 1, -32'd5, 9);

        for (int i = 0; i < 40; i++)
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());

        begin
            int k = 0;
            while (sb.size() != 0 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("drain", 64'(sb.size()), 0);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
